// File: rtl/trigger_capture.sv
// Ring-buffer capture of a pre/post-trigger frame around a trigger rising edge,
// streamed out over valid/ready and automatically re-armed after the last word.
module trigger_capture #(
  parameter int DW         = 16,
  parameter int AW         = 4,
  parameter int PRE        = 4,
  parameter int POST       = 4,
  parameter int TRIG_DELAY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          trigger_in,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          armed,
  output logic [7:0]    missed_cnt
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = AW + 1;

  localparam logic [CW-1:0] FILL_TARGET = CW'(PRE + TRIG_DELAY);
  localparam logic [CW-1:0] FRAME_LEN   = CW'(PRE + POST);
  localparam logic [CW-1:0] POST_REM    = CW'(POST - TRIG_DELAY - 1);
  localparam logic [AW-1:0] BACK_OFF    = AW'(PRE + TRIG_DELAY);

  typedef enum logic [1:0] {S_FILL, S_ARMED, S_POST, S_READOUT} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_cnt_q, fill_cnt_d, fill_inc;
  logic [CW-1:0] post_left_q, post_left_d;
  logic [CW-1:0] rd_left_q, rd_left_d;
  logic          trig_q, trig_rise;
  logic [7:0]    missed_q, missed_d;
  logic [DW-1:0] buf_data_q [2];
  logic [1:0]    buf_last_q;
  logic          head_q, head_d;
  logic [1:0]    occ_q, occ_d;
  logic          wr_en, rd_issue, pop, tail, busy;

  assign trig_rise = trigger_in & ~trig_q;
  assign busy      = (state_q == S_POST) || (state_q == S_READOUT);
  assign wr_en     = din_valid && (state_q != S_READOUT);
  assign fill_inc  = fill_cnt_q + CW'(1);

  assign dout_valid = (occ_q != 2'd0);
  assign dout       = buf_data_q[head_q];
  assign dout_last  = dout_valid && buf_last_q[head_q];
  assign armed      = (state_q == S_ARMED);
  assign missed_cnt = missed_q;

  // Read/output pipeline: the output register plus one skid slot form a 2-entry FIFO.
  // A read may be issued whenever a slot is free now or is freed by this cycle's pop.
  assign pop      = dout_valid && dout_ready;
  assign rd_issue = (state_q == S_READOUT) && (rd_left_q != '0) && (!occ_q[1] || pop);
  assign tail     = head_q ^ occ_q[0];
  assign head_d   = head_q ^ pop;

  always_comb begin
    occ_d = occ_q;
    if (rd_issue && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!rd_issue && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
  end

  assign missed_d = (trig_rise && busy && (missed_q != 8'hFF)) ? missed_q + 8'd1 : missed_q;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    post_left_d = post_left_q;
    rd_left_d   = rd_left_q;
    rd_ptr_d    = rd_ptr_q;
    unique case (state_q)
      S_FILL: begin
        if (din_valid) begin
          fill_cnt_d = fill_inc;
          if (fill_inc == FILL_TARGET) begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        // Without a sample this cycle the trigger refers to the last written one.
        if (trig_rise) begin
          rd_ptr_d    = din_valid ? (wr_ptr_q - BACK_OFF) : (wr_ptr_q - BACK_OFF - AW'(1));
          post_left_d = POST_REM;
          state_d     = S_POST;
        end
      end
      S_POST: begin
        if (post_left_q == '0) begin
          state_d   = S_READOUT;
          rd_left_d = FRAME_LEN;
        end else if (din_valid) begin
          post_left_d = post_left_q - CW'(1);
          if (post_left_q == CW'(1)) begin
            state_d   = S_READOUT;
            rd_left_d = FRAME_LEN;
          end
        end
      end
      S_READOUT: begin
        if (rd_issue) begin
          rd_ptr_d  = rd_ptr_q + AW'(1);
          rd_left_d = rd_left_q - CW'(1);
        end
        if (pop && buf_last_q[head_q]) begin
          state_d    = S_FILL;
          fill_cnt_d = '0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      post_left_q   <= '0;
      rd_left_q     <= '0;
      trig_q        <= 1'b0;
      missed_q      <= '0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      head_q        <= 1'b0;
      occ_q         <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_left_q <= post_left_d;
      rd_left_q   <= rd_left_d;
      trig_q      <= trigger_in;
      missed_q    <= missed_d;
      head_q      <= head_d;
      occ_q       <= occ_d;
      if (rd_issue) begin
        buf_data_q[tail] <= mem[rd_ptr_q];
        buf_last_q[tail] <= (rd_left_q == CW'(1));
      end
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: expected frame words are queued when a trigger
// is driven and compared as the consumer accepts them.
module tb_trigger_capture;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int PRE = 4;
  localparam int POST = 4;
  localparam int TD = 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          trigger_in;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          armed;
  logic [7:0]    missed_cnt;

  word_t         expQ[$];
  int            errors = 0;
  int            checks = 0;
  int            popCount = 0;
  int            sampleIdx = 0;
  int            trigVal;
  logic          prevValid = 1'b0;
  logic          prevReady = 1'b0;
  logic [DW-1:0] prevDout = '0;
  logic          prevLast = 1'b0;

  trigger_capture #(
    .DW(DW), .AW(AW), .PRE(PRE), .POST(POST), .TRIG_DELAY(TD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .trigger_in(trigger_in),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last(dout_last),
    .armed(armed),
    .missed_cnt(missed_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame for a trigger seen with sample v: reference v-TD, words ref-PRE .. ref+POST-1.
  task automatic pushFrame(input int v);
    word_t w;
    for (int k = 0; k < PRE + POST; k++) begin
      w.data = DW'(v - TD - PRE + k);
      w.last = (k == PRE + POST - 1);
      expQ.push_back(w);
    end
  endtask

  task automatic checkOutput();
    word_t w;
    if (prevValid && !prevReady) begin
      checkEq("hold_valid", 32'(dout_valid), 32'd1);
      checkEq("hold_data", 32'(dout), 32'(prevDout));
      checkEq("hold_last", 32'(dout_last), 32'(prevLast));
    end
    if (dout_valid && dout_ready) begin
      checks++;
      assert (expQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_word observed=%0d expected=none", dout);
      end
      if (expQ.size() != 0) begin
        w = expQ.pop_front();
        checkEq("dout", 32'(dout), 32'(w.data));
        checkEq("dout_last", 32'(dout_last), 32'(w.last));
        popCount++;
      end
    end
    prevValid = dout_valid;
    prevReady = dout_ready;
    prevDout  = dout;
    prevLast  = dout_last;
  endtask

  task automatic applyStimulus(input logic trig, input logic rdy, input logic vld);
    @(negedge clk);
    trigger_in = trig;
    dout_ready = rdy;
    din_valid  = vld;
    din        = DW'(sampleIdx);
    if (vld) sampleIdx++;
    #1 checkOutput();
  endtask

  task automatic runSamples(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, rdy, 1'b1);
  endtask

  task automatic drain(input logic toggle);
    for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
      applyStimulus(1'b0, toggle ? ~i[0] : 1'b1, 1'b1);
    end
    checkEq("drain_done", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    trigger_in = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    din        = '0;
    sampleIdx  = 0;
    prevValid  = 1'b0;
    expQ.delete();
    repeat (2) @(negedge clk);
    checkEq("rst_dout_valid", 32'(dout_valid), 32'd0);
    checkEq("rst_dout_last", 32'(dout_last), 32'd0);
    checkEq("rst_dout", 32'(dout), 32'd0);
    checkEq("rst_armed", 32'(armed), 32'd0);
    checkEq("rst_missed", 32'(missed_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();

    // Held trigger rising with sample 11 gives a single frame 6..13.
    runSamples(11, 1'b1);
    checkEq("armed_before_trig", 32'(armed), 32'd1);
    pushFrame(11);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);
    drain(1'b0);
    checkEq("missed_after_hold", 32'(missed_cnt), 32'd0);

    // Same trigger shape with a stalling consumer.
    runSamples(6, 1'b1);
    checkEq("armed_rearm", 32'(armed), 32'd1);
    trigVal = sampleIdx;
    pushFrame(trigVal);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);
    drain(1'b1);

    // Edge during FILL is ignored; later edges during POST and READOUT are missed.
    doReset();
    runSamples(2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkEq("fill_edge_armed", 32'(armed), 32'd0);
    checkEq("fill_edge_missed", 32'(missed_cnt), 32'd0);
    runSamples(20 - sampleIdx, 1'b1);
    pushFrame(20);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    drain(1'b0);
    checkEq("missed_two", 32'(missed_cnt), 32'd2);

    // 300 busy edges while the consumer stalls saturate the missed counter.
    runSamples(6, 1'b1);
    trigVal = sampleIdx;
    pushFrame(trigVal);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
    end
    checkEq("missed_saturated", 32'(missed_cnt), 32'd255);
    applyStimulus(1'b0, 1'b1, 1'b1);
    drain(1'b0);

    // Frame that wraps around the ring end.
    doReset();
    runSamples(17, 1'b1);
    pushFrame(17);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    drain(1'b0);

    // Reset in the middle of a readout aborts the frame immediately.
    runSamples(6, 1'b1);
    trigVal = sampleIdx;
    pushFrame(trigVal);
    applyStimulus(1'b1, 1'b1, 1'b1);
    popCount = 0;
    for (int i = 0; i < 40 && popCount < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkEq("three_popped", 32'(popCount), 32'd3);
    checkEq("pre_abort_valid", 32'(dout_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkEq("abort_valid", 32'(dout_valid), 32'd0);
    checkEq("abort_last", 32'(dout_last), 32'd0);
    expQ.delete();
    prevValid  = 1'b0;
    trigger_in = 1'b0;
    din_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    checkEq("refill_4_armed", 32'(armed), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkEq("refill_5_pending", 32'(armed), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkEq("refill_5_armed", 32'(armed), 32'd1);
    checkEq("refill_missed", 32'(missed_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
